// File: rtl/jt7759_dbuf.sv
// Sample-data prefetch FIFO between the jt7759 control FSM and its byte source:
// ROM in master mode (mdn=1) or host CPU writes paced by DRQn in slave mode (mdn=0).
module jt7759_dbuf #(
  parameter int DW     = 8,
  parameter int AW     = 17,
  parameter int DEPTHW = 2,
  parameter int GAP    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen_ctl,
  input  logic              mdn,
  input  logic              ctrl_busyn,
  input  logic              ctrl_ld,
  input  logic [AW-1:0]     ctrl_addr,
  input  logic              ctrl_cs,
  output logic [DW-1:0]     ctrl_din,
  output logic              ctrl_ok,
  output logic [DEPTHW:0]   level,
  output logic              ovf,
  output logic              rom_cs,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data,
  input  logic              rom_ok,
  input  logic              cs,
  input  logic              wrn,
  input  logic [DW-1:0]     din,
  output logic              drqn
);

  localparam int DEPTH = 1 << DEPTHW;
  localparam int LW    = DEPTHW + 1;
  localparam int GW    = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [LW-1:0]     LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]     LVL_ONE  = LW'(1);
  localparam logic [DEPTHW-1:0] PTR_ONE  = DEPTHW'(1);
  localparam logic [AW-1:0]     ADDR_ONE = AW'(1);
  localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP);
  localparam logic [GW-1:0]     GAP_ONE  = GW'(1);

  logic [DW-1:0]     mem_q [DEPTH];

  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic              drqn_q, drqn_d;
  logic              drqn_l_q, drqn_l_d;
  logic              pending_q, pending_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DEPTHW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTHW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [DW-1:0]     ctrl_din_q, ctrl_din_d;
  logic              ctrl_ok_q, ctrl_ok_d;
  logic              readout_q, readout_d;
  logic              ctrl_cs_l_q, ctrl_cs_l_d;
  logic              wr_l_q, wr_l_d;

  logic              push, pop, full, accept, request;
  logic              wr_now, wr_ev, cs_rise;
  logic [DW-1:0]     push_data;

  always_comb begin
    rom_addr_d  = rom_addr_q;
    drqn_d      = drqn_q;
    pending_d   = pending_q;
    gap_d       = gap_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    ctrl_din_d  = ctrl_din_q;
    ctrl_ok_d   = ctrl_ok_q;
    readout_d   = readout_q;
    push        = 1'b0;
    push_data   = '0;

    drqn_l_d    = drqn_q;
    ctrl_cs_l_d = ctrl_cs;
    wr_now      = cs & ~wrn;
    wr_l_d      = wr_now;
    wr_ev       = ~mdn & wr_now & ~wr_l_q;
    cs_rise     = ctrl_cs & ~ctrl_cs_l_q;
    full        = (level_q == LVL_FULL);
    // drqn must already have been low on the previous clk so the ROM saw a settled address
    accept      = mdn & pending_q & ~drqn_q & ~drqn_l_q & rom_ok;
    request     = ~pending_q & ~full & (gap_q == '0);
    pop         = readout_q & (level_q != '0) & ~ctrl_ld & ~ctrl_busyn;

    if (!ctrl_cs) begin
      ctrl_ok_d = 1'b0;
      readout_d = 1'b0;
    end else if (cs_rise) begin
      readout_d = 1'b1;
      ctrl_ok_d = 1'b0;
    end else if (pop) begin
      ctrl_din_d = mem_q[rd_ptr_q];
      ctrl_ok_d  = 1'b1;
      readout_d  = 1'b0;
    end

    if (gap_q != '0 && cen_ctl) gap_d = gap_q - GAP_ONE;

    if (ctrl_ld) begin
      rom_addr_d = ctrl_addr;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drqn_d     = 1'b1;
      pending_d  = 1'b0;
      gap_d      = GAP_LOAD;
    end else if (ctrl_busyn) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drqn_d     = 1'b1;
      pending_d  = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      if (accept) begin
        push       = 1'b1;
        push_data  = rom_data;
        rom_addr_d = rom_addr_q + ADDR_ONE;
        drqn_d     = 1'b1;
        pending_d  = 1'b0;
        gap_d      = GAP_LOAD;
      end else if (wr_ev) begin
        if (!full) begin
          push      = 1'b1;
          push_data = din;
          if (pending_q) begin
            drqn_d    = 1'b1;
            pending_d = 1'b0;
            gap_d     = GAP_LOAD;
          end
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (request) begin
        drqn_d    = 1'b0;
        pending_d = 1'b1;
      end
    end

    // flush branches leave push/pop low, so they cannot undo the cleared pointers
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q  <= '0;
      drqn_q      <= 1'b1;
      drqn_l_q    <= 1'b1;
      pending_q   <= 1'b0;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      ctrl_din_q  <= '0;
      ctrl_ok_q   <= 1'b0;
      readout_q   <= 1'b0;
      ctrl_cs_l_q <= 1'b0;
      wr_l_q      <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      drqn_q      <= drqn_d;
      drqn_l_q    <= drqn_l_d;
      pending_q   <= pending_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      ctrl_din_q  <= ctrl_din_d;
      ctrl_ok_q   <= ctrl_ok_d;
      readout_q   <= readout_d;
      ctrl_cs_l_q <= ctrl_cs_l_d;
      wr_l_q      <= wr_l_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign ctrl_din = ctrl_din_q;
  assign ctrl_ok  = ctrl_ok_q;
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign rom_addr = rom_addr_q;
  assign drqn     = drqn_q;
  assign rom_cs   = mdn & ~drqn_q;

endmodule
